// File: rtl/servo_bank_pkg.sv
// Shared types, constants and helpers for the servo bank controller.
package servo_bank_pkg;

   typedef logic [0:0] dec_state_t;

   localparam dec_state_t StSelect = 1'b0;
   localparam dec_state_t StValue  = 1'b1;

   localparam logic [7:0] BcastSelDefault = 8'hFF;

   // Bits needed to count 0..n-1; never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/servo_slew_pwm.sv
// One servo channel: slew-limited current value plus registered raw PWM bit.
module servo_slew_pwm
   import servo_bank_pkg::*;
#(
   parameter int unsigned CW             = 18,
   parameter int unsigned MIN_PULSE_CLKS = 12000,
   parameter int unsigned STEP_CLKS      = 47,
   parameter logic [7:0]  RESET_VALUE    = 8'd127,
   parameter logic [7:0]  SLEW_STEP      = 8'd0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    target,
   input  logic [CW-1:0] cnt,
   input  logic          period_start,
   output logic          pwm_raw,
   output logic [7:0]    current
);

   localparam logic [CW-1:0] MinW  = CW'(MIN_PULSE_CLKS);
   localparam logic [CW-1:0] StepW = CW'(STEP_CLKS);

   logic [7:0]    cur_q, cur_d;
   logic [7:0]    up_diff, dn_diff;
   logic [CW-1:0] width;
   logic          raw_q;

   // Current only moves at a period boundary so a pulse is never reshaped mid-period.
   always_comb begin
      up_diff = target - cur_q;
      dn_diff = cur_q - target;
      cur_d   = cur_q;
      if (period_start) begin
         if (SLEW_STEP == 8'd0) begin
            cur_d = target;
         end else if (target > cur_q) begin
            cur_d = cur_q + ((up_diff < SLEW_STEP) ? up_diff : SLEW_STEP);
         end else begin
            cur_d = cur_q - ((dn_diff < SLEW_STEP) ? dn_diff : SLEW_STEP);
         end
      end
   end

   assign width = MinW + CW'(cur_q) * StepW;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_q <= RESET_VALUE;
         raw_q <= 1'b0;
      end else begin
         cur_q <= cur_d;
         raw_q <= (cnt < width);
      end
   end

   assign pwm_raw = raw_q;
   assign current = cur_q;

endmodule

// File: rtl/servo_bank_ctrl.sv
// N-channel servo controller: byte-stream frame decoder, shared PWM period counter
// and per-channel slew/PWM slices.
module servo_bank_ctrl
   import servo_bank_pkg::*;
#(
   parameter int unsigned N_CH           = 3,
   parameter int unsigned PERIOD_CLKS    = 240000,
   parameter int unsigned MIN_PULSE_CLKS = 12000,
   parameter int unsigned STEP_CLKS      = 47,
   parameter logic [7:0]  RESET_VALUE    = 8'd127,
   parameter logic [7:0]  SLEW_STEP      = 8'd0,
   parameter int unsigned TIMEOUT_CLKS   = 120000,
   parameter bit          INVERT_PWM     = 1'b1,
   parameter logic [7:0]  BCAST_SEL      = BcastSelDefault
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rx_valid,
   input  logic [7:0]      rx_byte,
   output logic [N_CH-1:0] pwm,
   output logic            period_start,
   output logic            frame_ok,
   output logic            frame_err
);

   localparam int unsigned    CW     = cnt_width(PERIOD_CLKS);
   localparam int unsigned    TW     = cnt_width(TIMEOUT_CLKS);
   localparam logic [CW-1:0]  CntMax = CW'(PERIOD_CLKS - 1);
   localparam logic [TW-1:0]  ToMax  = TW'(TIMEOUT_CLKS - 1);
   localparam logic [7:0]     NumCh  = 8'(N_CH);

   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ps_q;
   dec_state_t      state_q, state_d;
   logic [7:0]      sel_q, sel_d;
   logic            bcast_q, bcast_d;
   logic [TW-1:0]   to_q, to_d;
   logic            wr_en;
   logic            ok_q, ok_d, err_q, err_d;
   logic [7:0]      target_q [N_CH];
   logic [N_CH-1:0] raw;
   // Per-channel current values are kept only for debug visibility.
   logic [7:0]      current_unused [N_CH];

   assign cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;

   // period_start is registered so it stays low through reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         ps_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ps_q  <= (cnt_d == '0);
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      bcast_d = bcast_q;
      to_d    = to_q;
      wr_en   = 1'b0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         StSelect: begin
            if (rx_valid) begin
               to_d = '0;
               if (rx_byte < NumCh) begin
                  sel_d   = rx_byte;
                  bcast_d = 1'b0;
                  state_d = StValue;
               end else if (rx_byte == BCAST_SEL) begin
                  bcast_d = 1'b1;
                  state_d = StValue;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StValue: begin
            // A byte arriving on the expiry cycle still commits.
            if (rx_valid) begin
               wr_en   = 1'b1;
               ok_d    = 1'b1;
               state_d = StSelect;
            end else if (to_q == ToMax) begin
               err_d   = 1'b1;
               state_d = StSelect;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         default: state_d = StSelect;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StSelect;
         sel_q   <= '0;
         bcast_q <= 1'b0;
         to_q    <= '0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         bcast_q <= bcast_d;
         to_q    <= to_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) target_q[i] <= RESET_VALUE;
      end else if (wr_en) begin
         for (int i = 0; i < N_CH; i++) begin
            if (bcast_q || (sel_q == 8'(i))) target_q[i] <= rx_byte;
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      servo_slew_pwm #(
         .CW            (CW),
         .MIN_PULSE_CLKS(MIN_PULSE_CLKS),
         .STEP_CLKS     (STEP_CLKS),
         .RESET_VALUE   (RESET_VALUE),
         .SLEW_STEP     (SLEW_STEP)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .target      (target_q[g]),
         .cnt         (cnt_q),
         .period_start(ps_q),
         .pwm_raw     (raw[g]),
         .current     (current_unused[g])
      );
   end

   assign pwm          = raw ^ {N_CH{INVERT_PWM}};
   assign period_start = ps_q;
   assign frame_ok     = ok_q;
   assign frame_err    = err_q;

endmodule

// File: tb/tb_servo_bank_ctrl.sv
// Directed bench: frame decoding, timeout, broadcast, PWM widths and slew ramp.
module tb_servo_bank_ctrl;

   localparam int unsigned NCh     = 3;
   localparam int unsigned Period  = 1000;
   localparam int unsigned SPeriod = 600;

   typedef logic [NCh-1:0][15:0] widths_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst, rx_valid;
   logic [7:0]     rx_byte;
   logic [NCh-1:0] pwm;
   logic           period_start, frame_ok, frame_err;

   logic           rst_s, rx_valid_s;
   logic [7:0]     rx_byte_s;
   logic [0:0]     pwm_s;
   logic           period_start_s, frame_ok_s, frame_err_s;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int ok_cnt   = 0;
   int err_cnt  = 0;

   servo_bank_ctrl #(
      .N_CH          (NCh),
      .PERIOD_CLKS   (Period),
      .MIN_PULSE_CLKS(100),
      .STEP_CLKS     (2),
      .TIMEOUT_CLKS  (50)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_valid    (rx_valid),
      .rx_byte     (rx_byte),
      .pwm         (pwm),
      .period_start(period_start),
      .frame_ok    (frame_ok),
      .frame_err   (frame_err)
   );

   servo_bank_ctrl #(
      .N_CH          (1),
      .PERIOD_CLKS   (SPeriod),
      .MIN_PULSE_CLKS(50),
      .STEP_CLKS     (2),
      .SLEW_STEP     (8'd10),
      .TIMEOUT_CLKS  (50)
   ) dut_slew (
      .clk         (clk),
      .rst         (rst_s),
      .rx_valid    (rx_valid_s),
      .rx_byte     (rx_byte_s),
      .pwm         (pwm_s),
      .period_start(period_start_s),
      .frame_ok    (frame_ok_s),
      .frame_err   (frame_err_s)
   );

   always @(negedge clk) begin
      if (frame_ok === 1'b1) ok_cnt++;
      if (frame_err === 1'b1) err_cnt++;
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_s(input logic [7:0] b);
      @(negedge clk);
      rx_valid_s = 1'b1;
      rx_byte_s  = b;
      @(negedge clk);
      rx_valid_s = 1'b0;
   endtask

   task automatic wait_ps(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < Period + 10; i++) begin
         @(negedge clk);
         if (period_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Counts active-low cycles per channel over one period starting at a period_start sample.
   task automatic measure(input bit synced, output widths_t w);
      bit ok;
      w = '0;
      if (!synced) begin
         wait_ps(ok);
         if (!ok) begin
            chk_cnt++;
            $display("FAIL period_start_wait: period_start missing for %0d cycles", Period + 10);
            return;
         end
      end
      for (int i = 0; i < Period; i++) begin
         if (i != 0) @(negedge clk);
         for (int c = 0; c < NCh; c++) if (pwm[c] === 1'b0) w[c] = w[c] + 16'd1;
      end
   endtask

   task automatic measure_s(output int w);
      bit ok;
      w  = 0;
      ok = 1'b0;
      for (int i = 0; i < SPeriod + 10; i++) begin
         @(negedge clk);
         if (period_start_s === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk_cnt++;
         $display("FAIL slew_period_start_wait: period_start missing for %0d cycles",
                  SPeriod + 10);
         return;
      end
      for (int i = 0; i < SPeriod; i++) begin
         if (i != 0) @(negedge clk);
         if (pwm_s[0] === 1'b0) w++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rst_s = 1'b1;
      rx_valid = 1'b0; rx_byte = '0;
      rx_valid_s = 1'b0; rx_byte_s = '0;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if (pwm !== 3'b111) $display("FAIL reset_pwm: got %b want 111", pwm);
      else pass_cnt++;
      chk_cnt++;
      if ({frame_ok, frame_err, period_start} !== 3'b000)
         $display("FAIL reset_pulses: ok/err/ps got %b want 000",
                  {frame_ok, frame_err, period_start});
      else pass_cnt++;
      chk_cnt++;
      if (pwm_s !== 1'b1) $display("FAIL reset_pwm_slew: got %b want 1", pwm_s);
      else pass_cnt++;
      rst = 1'b0; rst_s = 1'b0;
   endtask

   task automatic test_idle();
      widths_t w;
      int ok0, err0;
      ok0 = ok_cnt; err0 = err_cnt;
      measure(1'b0, w);
      for (int c = 0; c < NCh; c++) begin
         chk_cnt++;
         if (w[c] !== 16'd354) $display("FAIL idle_width ch%0d: got %0d want 354", c, w[c]);
         else pass_cnt++;
      end
      #1;
      chk_cnt++;
      if ((ok_cnt - ok0) != 0 || (err_cnt - err0) != 0)
         $display("FAIL idle_pulses: ok %0d err %0d want 0 0", ok_cnt - ok0, err_cnt - err0);
      else pass_cnt++;
   endtask

   task automatic test_single_channel();
      widths_t w;
      bit ok;
      int ok0;
      ok0 = ok_cnt;
      wait_ps(ok);
      chk_cnt++;
      if (!ok) $display("FAIL single_sync: period_start got 0 want 1");
      else pass_cnt++;
      fork
         measure(1'b1, w);
         begin
            repeat (200) @(negedge clk);
            send_byte(8'h01);
            send_byte(8'h00);
            chk_cnt++;
            if (frame_ok !== 1'b1) $display("FAIL single_frame_ok: got %b want 1", frame_ok);
            else pass_cnt++;
         end
      join
      for (int c = 0; c < NCh; c++) begin
         chk_cnt++;
         if (w[c] !== 16'd354)
            $display("FAIL single_cur_period ch%0d: got %0d want 354", c, w[c]);
         else pass_cnt++;
      end
      measure(1'b0, w);
      chk_cnt++;
      if (w !== {16'd354, 16'd100, 16'd354})
         $display("FAIL single_next_period: got %0d/%0d/%0d want 354/100/354",
                  w[0], w[1], w[2]);
      else pass_cnt++;
      #1;
      chk_cnt++;
      if (ok_cnt - ok0 != 1) $display("FAIL single_ok_count: got %0d want 1", ok_cnt - ok0);
      else pass_cnt++;
   endtask

   task automatic test_broadcast();
      widths_t w;
      send_byte(8'hFF);
      send_byte(8'hC8);
      chk_cnt++;
      if (frame_ok !== 1'b1) $display("FAIL bcast_frame_ok: got %b want 1", frame_ok);
      else pass_cnt++;
      measure(1'b0, w);
      chk_cnt++;
      if (w !== {16'd500, 16'd500, 16'd500})
         $display("FAIL bcast_width: got %0d/%0d/%0d want 500/500/500", w[0], w[1], w[2]);
      else pass_cnt++;
   endtask

   task automatic test_bad_select();
      widths_t w;
      send_byte(8'h05);
      chk_cnt++;
      if ({frame_err, frame_ok} !== 2'b10)
         $display("FAIL badsel_err: err/ok got %b want 10", {frame_err, frame_ok});
      else pass_cnt++;
      send_byte(8'h02);
      send_byte(8'h10);
      chk_cnt++;
      if ({frame_err, frame_ok} !== 2'b01)
         $display("FAIL badsel_recover: err/ok got %b want 01", {frame_err, frame_ok});
      else pass_cnt++;
      measure(1'b0, w);
      chk_cnt++;
      if (w !== {16'd132, 16'd500, 16'd500})
         $display("FAIL badsel_width: got %0d/%0d/%0d want 500/500/132", w[0], w[1], w[2]);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      widths_t w;
      int ok0, err0;
      ok0 = ok_cnt; err0 = err_cnt;
      send_byte(8'h00);
      repeat (49) @(negedge clk);
      chk_cnt++;
      if (frame_err !== 1'b0) $display("FAIL timeout_early: got %b want 0", frame_err);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (frame_err !== 1'b1) $display("FAIL timeout_expiry: got %b want 1", frame_err);
      else pass_cnt++;
      repeat (10) @(negedge clk);
      send_byte(8'h40);
      chk_cnt++;
      if (frame_err !== 1'b1) $display("FAIL timeout_late_byte_err: got %b want 1", frame_err);
      else pass_cnt++;
      #1;
      chk_cnt++;
      if ((err_cnt - err0) != 2 || (ok_cnt - ok0) != 0)
         $display("FAIL timeout_counts: err %0d ok %0d want 2 0", err_cnt - err0, ok_cnt - ok0);
      else pass_cnt++;
      measure(1'b0, w);
      chk_cnt++;
      if (w !== {16'd132, 16'd500, 16'd500})
         $display("FAIL timeout_no_write: got %0d/%0d/%0d want 500/500/132", w[0], w[1], w[2]);
      else pass_cnt++;
      // Value byte sampled on the same cycle the timeout would fire.
      err0 = err_cnt;
      send_byte(8'h00);
      repeat (48) @(negedge clk);
      send_byte(8'h32);
      chk_cnt++;
      if ({frame_err, frame_ok} !== 2'b01)
         $display("FAIL expiry_race: err/ok got %b want 01", {frame_err, frame_ok});
      else pass_cnt++;
      repeat (3) @(negedge clk);
      #1;
      chk_cnt++;
      if (err_cnt != err0) $display("FAIL expiry_race_err: got %0d want 0", err_cnt - err0);
      else pass_cnt++;
      measure(1'b0, w);
      chk_cnt++;
      if (w !== {16'd132, 16'd500, 16'd200})
         $display("FAIL expiry_race_width: got %0d/%0d/%0d want 200/500/132", w[0], w[1], w[2]);
      else pass_cnt++;
   endtask

   task automatic test_slew();
      int w, exp_cur;
      bit done;
      send_s(8'h00);
      send_s(8'h00);
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         measure_s(w);
         if (w == 50) done = 1'b1;
      end
      chk_cnt++;
      if (w != 50) $display("FAIL slew_reach_zero: width got %0d want 50", w);
      else pass_cnt++;
      send_s(8'h00);
      send_s(8'hFF);
      for (int i = 1; i <= 26; i++) begin
         exp_cur = (i < 26) ? 10 * i : 255;
         measure_s(w);
         chk_cnt++;
         if (w != 50 + 2 * exp_cur)
            $display("FAIL slew_ramp step%0d: width got %0d want %0d", i, w, 50 + 2 * exp_cur);
         else pass_cnt++;
      end
      send_s(8'h00);
      send_s(8'h00);
      measure_s(w);
      chk_cnt++;
      if (w != 540) $display("FAIL slew_down1: width got %0d want 540", w);
      else pass_cnt++;
      measure_s(w);
      chk_cnt++;
      if (w != 520) $display("FAIL slew_down2: width got %0d want 520", w);
      else pass_cnt++;
      repeat (100) @(negedge clk);
      rst_s = 1'b1;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if (pwm_s !== 1'b1) $display("FAIL slew_rst_pwm: got %b want 1", pwm_s);
      else pass_cnt++;
      rst_s = 1'b0;
      measure_s(w);
      chk_cnt++;
      if (w != 304) $display("FAIL slew_rst_value: width got %0d want 304", w);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single_channel();
      test_broadcast();
      test_bad_select();
      test_timeout();
      test_slew();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/servo_bank_ctrl.md
Name: servo_bank_ctrl

Overview:
- Parametrised N-channel servo controller fed by a byte stream from uart_rx (o_Rx_DV / o_Rx_Byte).
- Decodes two-byte frames (select, value) into per-channel 8-bit targets, with a broadcast select and an inter-byte timeout.
- Optionally slew-limits each channel toward its target.
- Generates N phase-aligned PWM outputs with configurable polarity. Everything runs in the clk domain; no logic is clocked by rx_valid.

Parameters:
- N_CH, 3, number of servo channels (1..254).
- PERIOD_CLKS, 240000, PWM period in clk cycles (20 ms at 12 MHz).
- MIN_PULSE_CLKS, 12000, pulse width for value 0.
- STEP_CLKS, 47, extra pulse clocks per value LSB. Constraint: MIN_PULSE_CLKS + 255*STEP_CLKS < PERIOD_CLKS.
- RESET_VALUE, 127, target and current value of every channel after reset.
- SLEW_STEP, 0, max change of the current value per PWM period; 0 = jump straight to target.
- TIMEOUT_CLKS, 120000, max gap between select and value bytes before the frame is abandoned.
- INVERT_PWM, 1, 1 = outputs active-low (inverting driver stage).
- BCAST_SEL, 8'hFF, select byte that addresses all channels.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_byte is valid.
- rx_byte  in  8  received byte.
- pwm  out  N_CH  servo drive, bit i = channel i, polarity per INVERT_PWM.
- period_start  out  1  one-cycle pulse on the first clock of each PWM period.
- frame_ok  out  1  one-cycle pulse when a value byte is committed.
- frame_err  out  1  one-cycle pulse on an invalid select byte or a timeout.

Behaviour:
Reset (synchronous, active-high)
- Decoder state = SELECT; period counter = 0; timeout counter = 0.
- All targets and current values = RESET_VALUE.
- pwm at inactive level: all ones if INVERT_PWM=1, else zeros.
- period_start, frame_ok, frame_err = 0.
- Reset mid-frame discards the pending select with no error pulse.

Decoder FSM
- SELECT:
  - rx_valid with rx_byte < N_CH: latch channel index, go to VALUE.
  - rx_byte == BCAST_SEL: set broadcast flag, go to VALUE.
  - Any other byte: frame_err pulse next cycle, stay in SELECT.
- VALUE:
  - rx_valid: write rx_byte to the target of the latched channel, or to all targets if broadcast. frame_ok pulses the next cycle; return to SELECT.
  - Timeout counter increments each cycle without rx_valid. On reaching TIMEOUT_CLKS-1: frame_err pulse, return to SELECT, no write.
  - If rx_valid coincides with timeout expiry, rx_valid wins: the write happens and no error is raised.
- The target register updates on the cycle after rx_valid.

PWM timing
- Period counter runs 0..PERIOD_CLKS-1, then wraps.
- period_start = 1 while the counter == 0.

Current-value update (at counter == 0 only)
- SLEW_STEP = 0: current = target.
- Otherwise: current moves toward target by min(SLEW_STEP, |target - current|). Unsigned 8-bit, no overshoot, no wrap.
- Targets written mid-period take effect at the next period start. Pulses are never truncated or extended mid-period.

Pulse generation
- width_i = MIN_PULSE_CLKS + current_i*STEP_CLKS, computed in ceil(log2(PERIOD_CLKS)) bits.
- Raw output active while counter < width_i; pwm_i = raw XOR INVERT_PWM.
- pwm is registered: 1-cycle latency from the counter.
- All channels rise together at period start.

Decomposition:
- Package servo_bank_pkg holds:
  - FSM state enum (SELECT, VALUE);
  - BCAST_SEL default;
  - function computing counter width (clog2).
- Natural sub-module: servo_slew_pwm, one per channel. Inputs: clk, rst, target, period counter, period_start. Outputs: the registered raw PWM bit and the current value.
- The top level owns the shared counter, the decoder FSM, the target registers and the polarity inversion.

Test Plan:
Bench overrides: PERIOD_CLKS=1000, MIN_PULSE_CLKS=100, STEP_CLKS=2, TIMEOUT_CLKS=50, N_CH=3.
1. Reset release, no traffic -> every channel active for 100+127*2 = 354 clocks per 1000-clock period; pwm low while active (INVERT_PWM=1); frame_ok and frame_err stay 0.
2. Bytes 0x01 then 0x00 -> one frame_ok pulse; from the next period, ch1 width = 100 while ch0 and ch2 stay at 354; the current period is not altered.
3. Bytes 0xFF then 0xC8 -> all three channels at width 500 from the next period start.
4. Byte 0x05 -> frame_err pulse, FSM stays in SELECT; then 0x02, 0x10 -> ch2 width = 132.
5. Byte 0x00, then 60 idle cycles, then 0x40 -> frame_err at timeout; 0x40 is treated as a select and raises a second frame_err; ch0 unchanged. Separately, a value byte arriving exactly on the expiry cycle is committed with no error.
6. SLEW_STEP=10, ch0 target 0->255 -> current goes 0,10,...,250,255 on successive period starts; no overshoot; rst asserted mid-ramp returns current to 127.
